// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter controller for the fetch stage. Owns the PC register and
//   sequences it through start/run, stall hold, taken-branch redirect with a
//   one-cycle fetch bubble, and a sticky halt.
//
// Ports
//   clk            core clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          begin fetching at RESET_PC (honoured in IDLE/HALT only)
//   stall          hold PC this cycle
//   branch_taken   redirect PC to branch_target (enters one-cycle bubble)
//   branch_target  absolute redirect address
//   halt_req       stop fetching; sticky until the next start
//   pc             current fetch address
//   pc_valid       pc is a real fetch this cycle
//   halted         sequencer is halted
//   pc_wrap        one-cycle pulse when pc incremented from all-ones to zero
module pc_sequencer #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            halt_req,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            halted,
  output logic            pc_wrap
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PC_W-1:0] pc_d;
  logic            wrap_d;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc + PC_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    wrap_d  = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
        end
      end
      S_RUN: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (branch_taken) begin
          state_d = S_FLUSH;
          pc_d    = branch_target;
        end else if (!stall) begin
          pc_d   = pc_inc;
          wrap_d = (pc == '1);
        end
      end
      S_FLUSH: begin
        state_d = halt_req ? S_HALT : S_RUN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs are derived from the next state so they register on the
  // same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc       <= RESET_PC;
      pc_valid <= 1'b0;
      halted   <= 1'b0;
      pc_wrap  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc       <= pc_d;
      pc_valid <= (state_d == S_RUN);
      halted   <= (state_d == S_HALT);
      pc_wrap  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer: directed scenarios followed by a
//   randomized run, every cycle compared against a behavioural model.
module tb_pc_sequencer;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = '0;
  logic        halt_req = 1'b0;
  logic [15:0] pc;
  logic        pc_valid;
  logic        halted;
  logic        pc_wrap;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: mode names, integer PC arithmetic modulo 2^16.
  localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2, M_HALT = 3;
  int m_mode;
  int m_pc;
  int m_wrap;

  pc_sequencer #(.PC_W(16), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .halted        (halted),
    .pc_wrap       (pc_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_pc   = int'(RESET_PC);
    m_wrap = 0;
  endtask

  task automatic model_step(input bit s, input bit st, input bit br,
                            input int tgt, input bit h);
    m_wrap = 0;
    if (m_mode == M_IDLE || m_mode == M_HALT) begin
      if (s) begin
        m_mode = M_RUN;
        m_pc   = int'(RESET_PC);
      end
    end else if (m_mode == M_FLUSH) begin
      m_mode = h ? M_HALT : M_RUN;
    end else begin
      if (h)       m_mode = M_HALT;
      else if (br) begin
        m_mode = M_FLUSH;
        m_pc   = tgt;
      end else if (!st) begin
        m_wrap = (m_pc == 65535) ? 1 : 0;
        m_pc   = (m_pc + 1) % 65536;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pc"},       32'(pc),       32'(m_pc));
    check({tag, ".pc_valid"}, 32'(pc_valid), 32'(m_mode == M_RUN));
    check({tag, ".halted"},   32'(halted),   32'(m_mode == M_HALT));
    check({tag, ".pc_wrap"},  32'(pc_wrap),  32'(m_wrap));
  endtask

  // One clock: drive inputs, let the edge happen, update model, compare 1ns later.
  task automatic cycle(input string tag, input bit s, input bit st, input bit br,
                       input logic [15:0] tgt, input bit h);
    start = s; stall = st; branch_taken = br; branch_target = tgt; halt_req = h;
    @(posedge clk);
    model_step(s, st, br, int'(tgt), h);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from the clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    #2;
    rst_n = 1'b1;
  endtask

  // Redirect into RUN at a given address (branch, bubble, then fetching target).
  task automatic goto_pc(input string tag, input logic [15:0] a);
    cycle(tag, 1'b0, 1'b0, 1'b1, a, 1'b0);
    cycle(tag, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    model_reset();
    start = 1'b0;
    #3;
    compare_all("reset");
    #14;
    rst_n = 1'b1;

    // T1: idle before start, then counting from RESET_PC
    idle("t1_pre", 3);
    check("t1_pre_valid", 32'(pc_valid), 32'd0);
    cycle("t1_start", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    check("t1_pc0", 32'(pc), 32'h0);
    check("t1_valid0", 32'(pc_valid), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      idle("t1_run", 1);
      check("t1_pcn", 32'(pc), 32'(i));
    end

    // T2: stall hold
    goto_pc("t2_goto", 16'h0010);
    check("t2_pc10", 32'(pc), 32'h10);
    for (int i = 0; i < 3; i++) begin
      cycle("t2_stall", 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      check("t2_hold", 32'(pc), 32'h10);
      check("t2_valid", 32'(pc_valid), 32'd1);
    end
    idle("t2_go", 1);
    check("t2_pc11", 32'(pc), 32'h11);

    // T3: branch overrides stall, one bubble
    goto_pc("t3_goto", 16'h0020);
    cycle("t3_br", 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0);
    check("t3_tgt", 32'(pc), 32'h1234);
    check("t3_bubble", 32'(pc_valid), 32'd0);
    cycle("t3_flush", 1'b0, 1'b1, 1'b1, 16'h5555, 1'b0);
    check("t3_fetch", 32'(pc), 32'h1234);
    check("t3_valid", 32'(pc_valid), 32'd1);
    idle("t3_inc", 1);
    check("t3_pc1235", 32'(pc), 32'h1235);

    // T4: wrap
    goto_pc("t4_goto", 16'hFFFE);
    check("t4_fffe", 32'(pc), 32'hFFFE);
    check("t4_nowrap0", 32'(pc_wrap), 32'd0);
    idle("t4_run", 1);
    check("t4_ffff", 32'(pc), 32'hFFFF);
    check("t4_nowrap1", 32'(pc_wrap), 32'd0);
    idle("t4_run", 1);
    check("t4_0000", 32'(pc), 32'h0);
    check("t4_wrap", 32'(pc_wrap), 32'd1);
    idle("t4_run", 1);
    check("t4_wrap_clr", 32'(pc_wrap), 32'd0);

    // T5: halt beats branch, frozen, restart
    goto_pc("t5_goto", 16'h0040);
    cycle("t5_halt", 1'b0, 1'b0, 1'b1, 16'h7777, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle("t5_frozen", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            16'($urandom), 1'($urandom_range(0, 1)));
      check("t5_pc", 32'(pc), 32'h40);
      check("t5_halted", 32'(halted), 32'd1);
    end
    cycle("t5_start", 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    check("t5_restart_pc", 32'(pc), 32'(RESET_PC));
    check("t5_restart_valid", 32'(pc_valid), 32'd1);
    check("t5_restart_halted", 32'(halted), 32'd0);

    // T6: async reset mid-bubble
    goto_pc("t6_goto", 16'h0100);
    cycle("t6_br", 1'b0, 1'b0, 1'b1, 16'h0ABC, 1'b0);
    async_reset("t6_rst");
    check("t6_pc", 32'(pc), 32'(RESET_PC));
    check("t6_valid", 32'(pc_valid), 32'd0);
    idle("t6_idle", 5);
    check("t6_still_idle", 32'(pc_valid), 32'd0);

    // Randomized run with occasional async resets; targets biased near wrap.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                        : 16'($urandom);
      cycle("rand", $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, tgt, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
